// File: rtl/conv_pkg.sv
// Shared definitions for the conv result/feeder streamers: element width,
// streamer FSM encoding and a width helper.
package conv_pkg;

    localparam int FP16_WIDTH = 16;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_SEND = 1'b1;

    typedef enum logic {
        S_IDLE = STATE_IDLE,
        S_SEND = STATE_SEND
    } stream_state_t;

    // Counter/tag width for n distinct values; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_idx_counter.sv
// Nested channel/row/column position counter with a flat element index.
// Walks ch-major, then row, then col; wraps to zero after the last element.
module conv_idx_counter
    import conv_pkg::*;
#(
    parameter  int CH  = 1,
    parameter  int RL  = 78,
    parameter  int RW  = 78,
    localparam int NUM = CH * RL * RW,
    localparam int IW  = clog2_min1(NUM),
    localparam int CW  = clog2_min1(CH),
    localparam int LW  = clog2_min1(RL),
    localparam int WW  = clog2_min1(RW)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_advance,
    output logic [IW-1:0] o_idx,
    output logic [CW-1:0] o_ch,
    output logic [LW-1:0] o_row,
    output logic [WW-1:0] o_col,
    output logic          o_last
);

    localparam logic [IW-1:0] IDX_MAX = IW'(NUM - 1);
    localparam logic [LW-1:0] ROW_MAX = LW'(RL - 1);
    localparam logic [WW-1:0] COL_MAX = WW'(RW - 1);

    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_ch;
    logic [LW-1:0] r_row;
    logic [WW-1:0] r_col;
    logic          w_last;

    assign w_last = (r_idx == IDX_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
            r_ch  <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (i_clear || (i_advance && w_last)) begin
            r_idx <= '0;
            r_ch  <= '0;
            r_row <= '0;
            r_col <= '0;
        end else if (i_advance) begin
            r_idx <= r_idx + 1'b1;
            if (r_col == COL_MAX) begin
                r_col <= '0;
                if (r_row == ROW_MAX) begin
                    r_row <= '0;
                    r_ch  <= r_ch + 1'b1;
                end else begin
                    r_row <= r_row + 1'b1;
                end
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_idx  = r_idx;
    assign o_ch   = r_ch;
    assign o_row  = r_row;
    assign o_col  = r_col;
    assign o_last = w_last;

endmodule

// File: rtl/conv_result_streamer.sv
// Captures a complete conv result frame on out_valid and drains it one element
// per valid/ready handshake with ch/row/col tags, so conv_top can start the next frame.
module conv_result_streamer
    import conv_pkg::*;
#(
    parameter  int data_width     = FP16_WIDTH,
    parameter  int output_channel = 1,
    parameter  int result_width   = 78,
    parameter  int result_length  = 78,
    localparam int NUM = output_channel * result_length * result_width,
    localparam int IW  = clog2_min1(NUM),
    localparam int CW  = clog2_min1(output_channel),
    localparam int LW  = clog2_min1(result_length),
    localparam int WW  = clog2_min1(result_width)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [0:NUM*data_width-1] result,
    input  logic                      out_valid,
    output logic [data_width-1:0]     m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic                      m_last,
    output logic [CW-1:0]             m_ch,
    output logic [LW-1:0]             m_row,
    output logic [WW-1:0]             m_col,
    output logic                      busy,
    output logic                      overrun,
    input  logic                      clear_overrun
);

    stream_state_t             r_state;
    stream_state_t             w_next_state;
    logic [0:NUM*data_width-1] r_frame;
    logic                      r_overrun;
    logic                      w_capture;
    logic                      w_advance;
    logic                      w_overrun_set;
    logic                      w_last;
    logic [IW-1:0]             w_idx;
    logic [data_width-1:0]     w_elems [NUM];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        w_next_state  = r_state;
        w_capture     = 1'b0;
        w_advance     = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (out_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                w_advance = m_ready;
                if (m_ready && w_last) begin
                    // A new frame landing on the final handshake follows with no bubble.
                    if (out_valid) w_capture    = 1'b1;
                    else           w_next_state = S_IDLE;
                end else if (out_valid) begin
                    w_overrun_set = 1'b1;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: the frame register is reset on purpose: reset must leave m_data at
    // zero and discard any held frame, so it is not a plain unreset memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          r_frame <= '0;
        else if (w_capture) r_frame <= result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              r_overrun <= 1'b0;
        else if (w_overrun_set) r_overrun <= 1'b1;
        else if (clear_overrun) r_overrun <= 1'b0;
    end

    conv_idx_counter #(
        .CH (output_channel),
        .RL (result_length),
        .RW (result_width)
    ) u_idx_counter (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_capture),
        .i_advance (w_advance),
        .o_idx     (w_idx),
        .o_ch      (m_ch),
        .o_row     (m_row),
        .o_col     (m_col),
        .o_last    (w_last)
    );

    for (genvar g = 0; g < NUM; g++) begin : g_elem
        assign w_elems[g] = r_frame[g*data_width +: data_width];
    end

    assign m_data  = w_elems[w_idx];
    assign m_valid = (r_state == S_SEND);
    assign m_last  = w_last & m_valid;
    assign busy    = (r_state == S_SEND);
    assign overrun = r_overrun;

endmodule

// File: tb/tb_conv_result_streamer.sv
// Scoreboard bench for conv_result_streamer with a 2x2x3 frame (12 elements).
module tb_conv_result_streamer;

    localparam int DW  = 16;
    localparam int CH  = 2;
    localparam int RL  = 2;
    localparam int RW  = 3;
    localparam int NUM = CH * RL * RW;

    typedef struct packed {
        logic [15:0] data;
        logic [0:0]  ch;
        logic [0:0]  row;
        logic [1:0]  col;
        logic        last;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [0:NUM*DW-1] result;
    logic              out_valid;
    logic [DW-1:0]     m_data;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_last;
    logic [0:0]        m_ch;
    logic [0:0]        m_row;
    logic [1:0]        m_col;
    logic              busy;
    logic              overrun;
    logic              clear_overrun;

    beat_t exp_q[$];
    int    hs_cyc_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    ready_mode = 0;

    conv_result_streamer #(
        .data_width     (DW),
        .output_channel (CH),
        .result_width   (RW),
        .result_length  (RL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .result        (result),
        .out_valid     (out_valid),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_last        (m_last),
        .m_ch          (m_ch),
        .m_row         (m_row),
        .m_col         (m_col),
        .busy          (busy),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ready pattern: 0 = always ready, 1 = random, otherwise never ready.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic beat_t model(input logic [15:0] base, input int i);
        beat_t b;
        b.data = base + 16'(i);
        b.ch   = 1'(i / (RL * RW));
        b.row  = 1'((i % (RL * RW)) / RW);
        b.col  = 2'(i % RW);
        b.last = (i == NUM - 1);
        return b;
    endfunction

    task automatic load_result(input logic [15:0] base);
        for (int i = 0; i < NUM; i++)
            result = {result[DW:NUM*DW-1], base + 16'(i)};
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [15:0] base, input bit accept, output int pcyc);
        load_result(base);
        out_valid = 1'b1;
        pcyc = cyc + 1;
        if (accept)
            for (int i = 0; i < NUM; i++) exp_q.push_back(model(base, i));
        tick();
        out_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        check({name, "_pending"}, 64'(exp_q.size()), 64'(0));
        check({name, "_busy"}, 64'(busy), 64'(0));
    endtask

    task automatic check_timing(input string name, input int pcyc, input int nbeats);
        logic ok = (hs_cyc_q.size() == nbeats);
        for (int k = 0; k < hs_cyc_q.size(); k++)
            if (hs_cyc_q[k] != pcyc + 1 + k) ok = 1'b0;
        check(name, 64'(ok), 64'(1));
    endtask

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    beat_t prev_b;
    logic  prev_stall = 1'b0;
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = {m_data, m_ch, m_row, m_col, m_last};
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            check("busy_vs_valid", 64'(busy), 64'(m_valid));
            if (prev_stall) begin
                check("stall_valid", 64'(m_valid), 64'(1));
                check("stall_hold", 64'(cur), 64'(prev_b));
            end
            if (m_valid && m_ready) begin
                hs_cyc_q.push_back(cyc + 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(cur), 64'(e));
                end
            end
            if (!m_valid) check("last_idle", 64'(m_last), 64'(0));
            prev_stall = m_valid && !m_ready;
            prev_b     = cur;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        int   pc;
        int   pc2;
        logic seen;

        reset         = 1'b1;
        out_valid     = 1'b0;
        clear_overrun = 1'b0;
        result        = '0;
        ready_mode    = 1;

        // Inputs toggling under reset must not disturb any output.
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            out_valid     = k[0];
            clear_overrun = ~k[0];
            result        = {6{$urandom}};
            #2;
            check("reset_outputs",
                  64'({m_data, m_valid, m_last, m_ch, m_row, m_col, busy, overrun}), 64'(0));
        end
        out_valid     = 1'b0;
        clear_overrun = 1'b0;
        ready_mode    = 0;
        reset         = 1'b0;

        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            seen |= m_valid;
        end
        check("idle_no_valid", 64'(seen), 64'(0));

        // Full-rate frame: 12 beats on consecutive cycles, starting one cycle after the pulse.
        hs_cyc_q.delete();
        pulse(16'h3C00, 1'b1, pc);
        check("first_beat_valid", 64'(m_valid), 64'(1));
        check("first_beat_data", 64'(m_data), 64'(16'h3C00));
        wait_drain("frame1");
        check_timing("frame1_timing", pc, NUM);

        // Same frame under random backpressure.
        ready_mode = 1;
        hs_cyc_q.delete();
        pulse(16'h3C00, 1'b1, pc);
        wait_drain("frame_bp");
        check("frame_bp_beats", 64'(hs_cyc_q.size()), 64'(NUM));
        ready_mode = 0;

        // Frame arriving mid-stream is dropped and flags overrun; set beats clear.
        check("overrun_initial", 64'(overrun), 64'(0));
        pulse(16'h3D00, 1'b1, pc);
        tick(5);
        pulse(16'h5000, 1'b0, pc2);
        check("overrun_set", 64'(overrun), 64'(1));
        tick(2);
        load_result(16'h6000);
        out_valid     = 1'b1;
        clear_overrun = 1'b1;
        tick();
        out_valid     = 1'b0;
        clear_overrun = 1'b0;
        check("overrun_set_wins", 64'(overrun), 64'(1));
        wait_drain("overrun_frame");
        check("overrun_sticky", 64'(overrun), 64'(1));
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check("overrun_cleared", 64'(overrun), 64'(0));

        // Back-to-back: second pulse coincides with the final handshake of the first.
        hs_cyc_q.delete();
        pulse(16'h7000, 1'b1, pc);
        tick(11);
        pulse(16'h7100, 1'b1, pc2);
        check("b2b_next_valid", 64'(m_valid), 64'(1));
        check("b2b_next_data", 64'(m_data), 64'(16'h7100));
        wait_drain("b2b");
        check_timing("b2b_timing", pc, 2 * NUM);
        check("b2b_no_overrun", 64'(overrun), 64'(0));

        // Reset at beat 7 discards the frame; the next frame starts cleanly from element 0.
        pulse(16'h4000, 1'b1, pc);
        tick(7);
        check("pre_reset_data", 64'(m_data), 64'(16'h4007));
        reset = 1'b1;
        #1;
        check("reset_midframe",
              64'({m_valid, busy, m_last, m_data, m_ch, m_row, m_col}), 64'(0));
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        hs_cyc_q.delete();
        pulse(16'h4400, 1'b1, pc);
        wait_drain("post_reset");
        check_timing("post_reset_timing", pc, NUM);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
